p251_rej_sampler: RTL and testbench

P251_REJ_SAMPLER -- requirements
Module: p251_rej_sampler

---
 rtl/p251_rej_sampler_pkg.sv | 14 +
 rtl/p251_fifo.sv | 46 ++++
 rtl/p251_rej_sampler.sv | 92 +++++++++
 tb/tb_p251_rej_sampler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p251_rej_sampler_pkg.sv
// p251_rej_sampler_pkg: shared constants and FSM state type for the mod-251 rejection sampler
package p251_rej_sampler_pkg;

    localparam logic [7:0] P251      = 8'd251;
    localparam int         DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/p251_fifo.sv
// p251_fifo: synchronous FIFO with push/pop/full/empty and async active-low reset
module p251_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed when not empty
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/p251_rej_sampler.sv
// p251_rej_sampler: rejection-samples random bytes into field elements in [0,250]
module p251_rej_sampler
    import p251_rej_sampler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [7:0]       o_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_done,
    output logic [CNT_W-1:0] o_rej_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rej;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_data;
    logic             w_take;
    logic             w_keep;
    logic             w_pop;
    logic             w_start_ok;

    assign w_start_ok = i_start && (r_state == IDLE);
    assign o_ready    = (r_state == SAMPLE) && !w_full && (r_acc != r_target);
    assign w_take     = i_valid && o_ready;
    assign w_keep     = w_take && (i_data < P251);
    assign o_valid    = !w_empty;
    assign w_pop      = o_valid && i_ready;
    assign o_c        = w_empty ? 8'd0 : w_fifo_data;
    assign o_done     = (r_state == DONE);
    assign o_rej_cnt  = r_rej;

    p251_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_data  (i_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state: run until the target is accepted, then drain the buffer
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (i_count != '0) ? SAMPLE : DONE;
            SAMPLE:  if (r_acc == r_target) w_next = DRAIN;
            DRAIN:   if (w_empty) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Run counters: target latched on start, accepted and saturating reject counts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target <= '0;
            r_acc    <= '0;
            r_rej    <= '0;
        end else if (w_start_ok) begin
            r_target <= i_count;
            r_acc    <= '0;
            r_rej    <= '0;
        end else begin
            if (w_keep) r_acc <= r_acc + 1'b1;
            if (w_take && !w_keep && (r_rej != '1)) r_rej <= r_rej + 1'b1;
        end
    end

endmodule

// File: tb/tb_p251_rej_sampler.sv
// tb_p251_rej_sampler: directed scenarios plus random runs checked against a queue-based model
module tb_p251_rej_sampler;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [CW-1:0] count   = '0;
    logic [7:0]    data    = '0;
    logic          valid   = 1'b0;
    logic          rdy     = 1'b0;
    logic          rnd_rdy = 1'b0;
    logic          rr      = 1'b0;
    logic          i_ready_w;
    logic          o_ready;
    logic [7:0]    o_c;
    logic          o_valid;
    logic          o_done;
    logic [CW-1:0] o_rej_cnt;

    assign i_ready_w = rnd_rdy ? rr : rdy;

    always #5 clk = ~clk;

    p251_rej_sampler #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_count   (count),
        .i_data    (data),
        .i_valid   (valid),
        .o_ready   (o_ready),
        .o_c       (o_c),
        .o_valid   (o_valid),
        .i_ready   (i_ready_w),
        .o_done    (o_done),
        .o_rej_cnt (o_rej_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [7:0] dut_log[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 sampling, 2 draining, 3 done; buffer is a queue
    int         m_ph  = 0;
    int         m_tgt = 0;
    int         m_acc = 0;
    int         m_rej = 0;
    logic [7:0] m_q[$];

    function automatic bit m_ready();
        return (m_ph == 1) && (m_q.size() < DEPTH) && (m_acc < m_tgt);
    endfunction

    initial forever begin
        bit tk;
        bit pp;
        int nph;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_tgt = 0; m_acc = 0; m_rej = 0;
            m_q.delete();
        end else begin
            tk  = m_ready() && valid;
            pp  = (m_q.size() > 0) && i_ready_w;
            nph = m_ph;
            if (m_ph == 0 && start) begin
                nph   = (count != 0) ? 1 : 3;
                m_tgt = int'(count);
                m_acc = 0;
                m_rej = 0;
            end else if (m_ph == 1 && m_acc == m_tgt) nph = 2;
            else if (m_ph == 2 && m_q.size() == 0) nph = 3;
            else if (m_ph == 3) nph = 0;
            if (pp) void'(m_q.pop_front());
            if (tk) begin
                if (data < 8'd251) begin
                    m_q.push_back(data);
                    m_acc++;
                end else if (m_rej < 65535) m_rej++;
            end
            m_ph = nph;
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        check("ready", o_ready, m_ready());
        check("valid", o_valid, m_q.size() > 0);
        check("c", o_c, (m_q.size() > 0) ? m_q[0] : 0);
        check("done", o_done, m_ph == 3);
        check("rej", o_rej_cnt, m_rej);
        if (o_valid && i_ready_w) dut_log.push_back(o_c);
        if (o_done) n_done++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rr = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_start(input int c);
        dut_log.delete();
        count = CW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        int k = 0;
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        while (!o_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("feed_timeout", 0, 1);
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!o_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", o_done, 1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0;
        int c;
        int g;
        logic [7:0] b;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Mixed accept/reject, free-flowing output
        rdy = 1'b1;
        run_start(3);
        feed(8'd0); feed(8'd250); feed(8'd251); feed(8'd255); feed(8'd100);
        wait_done();
        check("s1_len", dut_log.size(), 3);
        if (dut_log.size() == 3) begin
            check("s1_c0", dut_log[0], 0);
            check("s1_c1", dut_log[1], 250);
            check("s1_c2", dut_log[2], 100);
        end
        check("s1_rej_hold", o_rej_cnt, 2);

        // Zero-length run
        run_start(0);
        @(negedge clk);
        check("s2_done", o_done, 1);
        check("s2_ready", o_ready, 0);
        tick();

        // Back-pressure fills the buffer
        rdy = 1'b0;
        run_start(6);
        for (int i = 0; i < 4; i++) feed(8'(10 + i * 20));
        repeat (10) begin
            @(negedge clk);
            check("s3_hold_c", o_c, 10);
            check("s3_full_ready", o_ready, 0);
        end
        tick();
        rdy = 1'b1;
        feed(8'd90); feed(8'd110);
        wait_done();
        check("s3_len", dut_log.size(), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++) check("s3_order", dut_log[i], 10 + i * 20);

        // Long reject streak
        run_start(2);
        for (int r = 0; r < 20; r++)
            for (int v = 251; v <= 255; v++) feed(8'(v));
        feed(8'd1); feed(8'd2);
        wait_done();
        check("s4_rej", o_rej_cnt, 100);
        check("s4_len", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("s4_c0", dut_log[0], 1);
            check("s4_c1", dut_log[1], 2);
        end

        // Reset mid-run
        rdy = 1'b0;
        run_start(5);
        feed(8'd3); feed(8'd4);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("s5_rst_ready", o_ready, 0);
            check("s5_rst_valid", o_valid, 0);
            check("s5_rst_c", o_c, 0);
            check("s5_rst_done", o_done, 0);
            check("s5_rst_rej", o_rej_cnt, 0);
        end
        tick();
        rst_n = 1'b1;
        d0 = n_done;
        repeat (5) tick();
        check("s5_no_done", n_done, d0);
        rdy = 1'b1;
        run_start(1);
        feed(8'd7);
        wait_done();
        check("s5_len", dut_log.size(), 1);
        if (dut_log.size() == 1) check("s5_c", dut_log[0], 7);

        // Restart attempt while sampling is ignored
        run_start(3);
        feed(8'd1);
        count = CW'(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(8'd2); feed(8'd3);
        wait_done();
        check("s6_len", dut_log.size(), 3);
        for (int i = 0; i < 3 && i < dut_log.size(); i++) check("s6_order", dut_log[i], i + 1);

        // Random runs with random downstream stalls and upstream gaps
        rnd_rdy = 1'b1;
        for (int r = 0; r < 15; r++) begin
            c = int'($urandom_range(0, 7));
            run_start(c);
            g = 0;
            while (m_acc < m_tgt && g < 200) begin
                if ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    tick();
                end
                b = $urandom_range(0, 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
                feed(b);
                g++;
            end
            wait_done();
            check("rand_len", dut_log.size(), c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
